// File: rtl/wall_drawer.sv
// wall_drawer: erases the previously drawn wall column band, then draws the
// wall at the newly latched position with a background-coloured hole.
// One pixel per cycle, column-outer / row-inner scan, fixed cycle count.
//
// Handshake: start is a one-cycle request honoured only in IDLE (busy=0);
// requests while busy are dropped, not queued. done pulses for exactly one
// cycle when the redraw finishes, and plot qualifies x_out/y_out/colour in
// the cycle it is high.
module wall_drawer #(
  parameter int         WALL_W      = 4,
  parameter int         HOLE_H      = 40,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] WALL_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] wall_x,
  input  logic [7:0] hole_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam int CW = (WALL_W > 1) ? $clog2(WALL_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WALL_W - 1);
  localparam logic [6:0]    ROW_LAST = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [6:0]    row;
  logic [7:0]    old_x, new_x, new_y;
  logic          old_valid;

  logic          scanning;
  logic          last_pixel;
  logic [7:0]    base_x;
  logic [7:0]    x_pix;
  logic [8:0]    hole_end;
  logic          in_hole;

  assign scanning   = (state == ERASE) || (state == DRAW);
  assign last_pixel = (col == COL_LAST) && (row == ROW_LAST);

  // Next-state decode: scan phases end on the last pixel of the band.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = old_valid ? ERASE : DRAW;
      ERASE: if (last_pixel) state_nxt = DRAW;
      DRAW:  if (last_pixel) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, scan counters and latched wall positions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      old_x     <= '0;
      new_x     <= '0;
      new_y     <= '0;
      old_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            new_x <= wall_x;
            new_y <= hole_y;
            col   <= '0;
            row   <= '0;
          end
        end
        ERASE, DRAW: begin
          // Counters wrap to zero on the last pixel, ready for the next phase.
          if (row == ROW_LAST) begin
            row <= '0;
            col <= (col == COL_LAST) ? '0 : col + 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end
        DONE: begin
          old_x     <= new_x;
          old_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pixel decode from registered state/counters only. The hole bound uses a
  // 9-bit sum so a hole running off the bottom is clipped rather than wrapped;
  // the column sum deliberately wraps mod 256 and is then clipped by plot.
  always_comb begin
    base_x   = (state == ERASE) ? old_x : new_x;
    x_pix    = base_x + 8'(col);
    hole_end = {1'b0, new_y} + 9'(HOLE_H);
    in_hole  = ({2'b00, row} >= {1'b0, new_y}) && ({2'b00, row} < hole_end);

    x_out  = '0;
    y_out  = '0;
    colour = '0;
    plot   = 1'b0;
    if (scanning) begin
      x_out  = x_pix;
      y_out  = row;
      colour = ((state == DRAW) && !in_hole) ? WALL_COLOUR : BG_COLOUR;
      plot   = ({1'b0, x_pix} < 9'(SCREEN_W));
    end
  end

  // Status outputs.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_wall_drawer.sv
// Directed bench for wall_drawer: each redraw is modelled pixel by pixel into
// an expected queue, then compared against the DUT one cycle at a time.
module tb_wall_drawer;

  localparam int W = 19; // {plot, colour[2:0], y[6:0], x[7:0]}

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] wall_x;
  logic [7:0] hole_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  int checks;
  int errors;
  int pix;

  logic [W-1:0] exp_q[$];

  bit         old_valid_m;
  logic [7:0] old_x_m;

  wall_drawer dut (
    .clk(clk), .reset(reset), .start(start), .wall_x(wall_x), .hole_y(hole_y),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s pix=%0d got=%0h exp=%0h", tag, pix, got, exp);
    end
  endtask

  // Expected pixel stream for one scan band.
  task automatic push_band(input logic [7:0] bx, input logic [7:0] hy, input bit is_draw);
    logic [7:0] xx;
    logic [6:0] yy;
    logic [2:0] cc;
    logic       pp;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 120; r++) begin
        xx = bx + 8'(c);
        yy = 7'(r);
        pp = (xx < 8'd160);
        cc = 3'b000;
        if (is_draw && !((r >= int'(hy)) && (r < int'(hy) + 40))) cc = 3'b010;
        exp_q.push_back({pp, cc, yy, xx});
      end
    end
  endtask

  task automatic check_pixel();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check("x_out",  32'(x_out),  32'(e[7:0]));
    check("y_out",  32'(y_out),  32'(e[14:8]));
    check("colour", 32'(colour), 32'(e[17:15]));
    check("plot",   32'(plot),   32'(e[18]));
    check("busy",   32'(busy),   32'd1);
    check("done",   32'(done),   32'd0);
  endtask

  // One redraw. poke: disturb start/wall_x/hole_y mid-scan and in the done
  // cycle. reset_at: draw-pixel index at which reset is applied (-1 = none).
  task automatic redraw(input logic [7:0] x, input logic [7:0] y, input bit poke,
                        input int reset_at);
    int n_erase;
    exp_q.delete();
    n_erase = old_valid_m ? 480 : 0;
    if (old_valid_m) push_band(old_x_m, 8'd0, 1'b0);
    push_band(x, y, 1'b1);

    @(negedge clk);
    wall_x = x; hole_y = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < n_erase + 480; i++) begin
      pix = i;
      check_pixel();
      if (poke && (i == 50 || i == n_erase + 300)) begin
        start = 1'b1; wall_x = x + 8'd7; hole_y = y + 8'd3;
      end else begin
        start = 1'b0;
      end
      if (reset_at >= 0 && i == n_erase + reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        for (int j = 0; j < 500; j++) begin
          @(negedge clk);
          if (done || plot || busy) check("rst_quiet", {29'd0, done, plot, busy}, 32'd0);
        end
        check("rst_quiet_end", {29'd0, done, plot, busy}, 32'd0);
        old_valid_m = 1'b0;
        old_x_m     = 8'd0;
        return;
      end
      @(negedge clk);
    end

    pix = -1;
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy",  32'(busy), 32'd1);
    check("done_plot",  32'(plot), 32'd0);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("stay_idle", {30'd0, busy, plot}, 32'd0);
    end
    old_valid_m = 1'b1;
    old_x_m     = x;
  endtask

  initial begin
    checks = 0; errors = 0; pix = -1;
    old_valid_m = 1'b0; old_x_m = 8'd0;
    reset = 1'b1; start = 1'b0; wall_x = 8'd0; hole_y = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_x",      32'(x_out),     32'd0);
    check("rst_y",      32'(y_out),     32'd0);
    check("rst_colour", 32'(colour),    32'd0);
    check("rst_plot",   32'(plot),      32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_state",  32'(state_dbg), 32'd0);

    redraw(8'd100, 8'd30,  1'b0, -1); // first draw, no erase
    redraw(8'd96,  8'd50,  1'b0, -1); // steady erase + draw
    redraw(8'd158, 8'd10,  1'b1, -1); // right-edge clip, busy disturbances
    redraw(8'd254, 8'd100, 1'b0, -1); // wrapped columns, hole at bottom
    redraw(8'd20,  8'd250, 1'b0, -1); // hole entirely below screen, no wrap
    redraw(8'd60,  8'd0,   1'b0, 200); // reset mid-DRAW
    redraw(8'd70,  8'd5,   1'b0, -1); // must skip erase after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
